nibble_serial_adder: RTL
========================

# nibble_serial_adder

Multi-cycle controller that adds two WIDTH-bit operands by sequencing one shared 4-bit `ripple_carry_adder` instance over WIDTH/4 nibbles, least-significant first. It handles the start/done handshake, the operand and result registers, and the nibble-to-nibble carry register. It sits between a requesting control unit and the 4-bit adder datapath, trading latency for area.

## Interface
- `WIDTH`, default 16, operand width in bits; must be a multiple of 4 and ≥ 8. N = WIDTH/4 nibbles.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: request; sampled only when `busy`=0.
- `A` input WIDTH: operand A; sampled on the accepting edge only.
- `B` input WIDTH: operand B; sampled on the accepting edge only.
- `Cin` input 1: carry-in for an add; sampled on the accepting edge.
- `op_sub` input 1: present only with `NSA_SUB_EN`; 1 selects A − B.
- `busy` output 1: 1 in RUN.
- `done` output 1: one-cycle pulse in DONE.
- `S` output WIDTH: result register.
- `Cout` output 1: final carry out.
- `ovf` output 1: two's-complement overflow of the final result.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- All outputs are 0 after reset: `S`=0, `Cout`=0, `ovf`=0, `busy`=0, `done`=0. Internal index and carry registers are also 0.
- IDLE, or DONE with `start`=1: accept the request.
  - Latch `A` into `a_r`. Latch `B` (or ~`B` for subtract) into `b_r`.
  - Set the carry register to `Cin` (or 1 for subtract).
  - Clear the nibble index and clear `S`. Go to RUN.
- IDLE with `start`=0: stay in IDLE.
- RUN, each cycle:
  - The adder sees `a_r[4i+3:4i]`, `b_r[4i+3:4i]` and the carry register, where i is the index.
  - Its sum is written to `S[4i+3:4i]`. Its carry out goes to the carry register.
  - The index increments.
  - On i = N−1: `Cout` takes the adder carry out, `ovf` is computed, and the FSM goes to DONE.
- DONE with `start`=0: return to IDLE.
- `ovf` = `a_r[WIDTH-1]` ^ `b_r[WIDTH-1]` ^ `S[WIDTH-1]` ^ `Cout`, evaluated on the final nibble.
- `start` is ignored while `busy`=1; a request made then is not queued.
- `S`, `Cout` and `ovf` hold their value until the next accepted request. That request clears `S`; `Cout` and `ovf` are overwritten on its final nibble.
- Reset asserted mid-RUN aborts the operation. All state returns to reset values and no `done` is produced.
- Results are modulo 2^WIDTH. `Cout` is the unsigned carry; for subtract, `Cout`=1 means no borrow.

## Timing
- Accepting edge = edge E0. RUN occupies the cycles after edges E0 … E(N−1).
- `busy` is high during exactly N cycles.
- `done` is high during the single cycle after edge EN, i.e. latency N+1 edges from the accepting edge. `S`, `Cout` and `ovf` are valid in that cycle.
- Back-to-back: `start` held high through DONE is accepted at the edge leaving DONE. Throughput is one result per N+1 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `NSA_SUB_EN` defined:
  - `op_sub` port exists.
  - With `op_sub`=1, the block computes A + ~B + 1 and ignores `Cin`.
- `NSA_SUB_EN` undefined:
  - No `op_sub` port.
  - The block computes A + B + `Cin` only.
  - No inversion logic is built.

## Test plan
- Reset (WIDTH=16) → `S`=0x0000, `Cout`=0, `ovf`=0, `busy`=0, `done`=0. Hold `start`=0 for 10 cycles → no change.
- A=0x1234, B=0x0FFF, Cin=0 → `busy` high for 4 cycles. `done` pulses on the 5th cycle with `S`=0x2233, `Cout`=0, `ovf`=0.
- A=0xFFFF, B=0x0001, Cin=0 → `S`=0x0000, `Cout`=1, `ovf`=0. A=0x7FFF, B=0x0001 → `S`=0x8000, `Cout`=0, `ovf`=1.
- With `NSA_SUB_EN`, `op_sub`=1, A=0x0005, B=0x0007, Cin=1 → `S`=0xFFFE, `Cout`=0, `ovf`=0 (Cin ignored). A=0x0007, B=0x0005 → `S`=0x0002, `Cout`=1.
- Start A=0x1111, B=0x2222. Pulse `start` again in RUN with A=0xFFFF → ignored; result `S`=0x3333. Then hold `start` through DONE with A=0x0001, B=0x0001 → second `done` 5 cycles later with `S`=0x0002.
- Assert `reset` in the 2nd RUN cycle → all outputs 0 immediately, no `done`. Next request A=0x00FF, B=0x0001 → `S`=0x0100.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder sequenced over one shared 4-bit ripple adder.
// Optional subtract support (op_sub port, A + ~B + 1) is built when NSA_SUB_EN is defined.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar k = 0; k < 4; k++) begin : g_fa
    assign s[k]   = a[k] ^ b[k] ^ c[k];
    assign c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
  end

  assign co = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef NSA_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       sum;
  logic             co;

  ripple_carry_adder u_rca (
    .a  (a_r[4*idx +: 4]),
    .b  (b_r[4*idx +: 4]),
    .ci (carry),
    .s  (sum),
    .co (co)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r <= A;
`ifdef NSA_SUB_EN
            b_r   <= op_sub ? ~B : B;
            carry <= op_sub ? 1'b1 : Cin;
`else
            b_r   <= B;
            carry <= Cin;
`endif
            idx   <= '0;
            S     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          S[4*idx +: 4] <= sum;
          carry         <= co;
          idx           <= idx + 1'b1;
          if (idx == LAST) begin
            // sum[3] is the new result MSB, not yet visible in S this cycle
            Cout  <= co;
            ovf   <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ sum[3] ^ co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
